// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: time-of-week keeper with NALM armed alarm slots and a
// ringer state machine (ring, snooze, auto-timeout). Binary field values are
// driven to external two-digit 7-segment drivers.
module multi_alarm_clock #(
    parameter int NS         = 60,
    parameter int NM         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int NALM       = 4,
    parameter int SNOOZE_SEC = 540,
    parameter int RING_SEC   = 60,
    localparam int SW        = (NALM > 1) ? $clog2(NALM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            timeset,
    input  logic            alarmset,
    input  logic            minadv,
    input  logic            hrsadv,
    input  logic            dayadv,
    input  logic [SW-1:0]   sel,
    input  logic [NALM-1:0] alarm_en,
    input  logic            snooze,
    input  logic            stop,
    output logic [6:0]      disp_sec,
    output logic [6:0]      disp_min,
    output logic [6:0]      disp_hrs,
    output logic [6:0]      disp_day,
    output logic            buzz,
    output logic [SW-1:0]   ring_id
);

    localparam int RCW = $clog2(RING_SEC + 1);
    localparam int SCW = $clog2(SNOOZE_SEC + 1);

    localparam logic [6:0]     SEC_MAX  = 7'(NS - 1);
    localparam logic [6:0]     MIN_MAX  = 7'(NM - 1);
    localparam logic [6:0]     HRS_MAX  = 7'(NH - 1);
    localparam logic [6:0]     DAY_MAX  = 7'(ND - 1);
    localparam logic [RCW-1:0] RING_MAX = RCW'(RING_SEC - 1);
    localparam logic [SCW-1:0] SNZ_LOAD = SCW'(SNOOZE_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    // Modular increment shared by every time and alarm field.
    function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] vmax);
        return (v == vmax) ? 7'd0 : v + 7'd1;
    endfunction

    logic [6:0] r_sec, r_min, r_hrs, r_day;
    logic [6:0] r_alm_min [NALM];
    logic [6:0] r_alm_hrs [NALM];
    logic [6:0] r_alm_day [NALM];
    logic       r_wrap;

    state_t         r_state,    w_state_nx;
    logic [SW-1:0]  r_ring_id,  w_ring_id_nx;
    logic [RCW-1:0] r_ring_cnt, w_ring_cnt_nx;
    logic [SCW-1:0] r_snz_cnt,  w_snz_cnt_nx;

    logic          w_alm_wr;
    logic          w_alm_view;
    logic          w_match;
    logic [SW-1:0] w_match_id;
    logic          w_ring_armed;

    assign w_alm_wr   = tick & alarmset & ~timeset & (32'(sel) < NALM);
    assign w_alm_view = alarmset & ~timeset;

    // Timekeeping with carry on normal ticks; carry-free field advance in time-set mode.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            r_sec <= '0;
            r_min <= '0;
            r_hrs <= '0;
            r_day <= '0;
        end else if (tick) begin
            if (!timeset) begin
                r_sec <= inc_wrap(r_sec, SEC_MAX);
                if (r_sec == SEC_MAX) begin
                    r_min <= inc_wrap(r_min, MIN_MAX);
                    if (r_min == MIN_MAX) begin
                        r_hrs <= inc_wrap(r_hrs, HRS_MAX);
                        if (r_hrs == HRS_MAX) begin
                            r_day <= inc_wrap(r_day, DAY_MAX);
                        end
                    end
                end
            end else begin
                if (minadv) r_min <= inc_wrap(r_min, MIN_MAX);
                if (hrsadv) r_hrs <= inc_wrap(r_hrs, HRS_MAX);
                if (dayadv) r_day <= inc_wrap(r_day, DAY_MAX);
            end
        end
    end

    // Alarm slot storage; only the selected slot advances during alarm set.
    always_ff @(posedge clk) begin
        // NOTE: the slot array is reset on purpose: every slot must read 00:00
        // day 0 after reset, so this is not left as an unreset memory.
        if (rst) begin
            for (int i = 0; i < NALM; i++) begin
                r_alm_min[i] <= '0;
                r_alm_hrs[i] <= '0;
                r_alm_day[i] <= '0;
            end
        end else if (w_alm_wr) begin
            for (int i = 0; i < NALM; i++) begin
                if (SW'(i) == sel) begin
                    if (minadv) r_alm_min[i] <= inc_wrap(r_alm_min[i], MIN_MAX);
                    if (hrsadv) r_alm_hrs[i] <= inc_wrap(r_alm_hrs[i], HRS_MAX);
                    if (dayadv) r_alm_day[i] <= inc_wrap(r_alm_day[i], DAY_MAX);
                end
            end
        end
    end

    // One-cycle flag marking a natural seconds rollover (never from manual set).
    always_ff @(posedge clk) begin
        if (rst) r_wrap <= 1'b0;
        else     r_wrap <= tick & ~timeset & (r_sec == SEC_MAX);
    end

    // Alarm compare; scanning downwards lets the lowest matching slot win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_match    = 1'b0;
        w_match_id = '0;
        for (int i = NALM - 1; i >= 0; i--) begin
            if (r_wrap && (r_sec == 7'd0) && alarm_en[i] &&
                (r_min == r_alm_min[i]) && (r_hrs == r_alm_hrs[i]) &&
                (r_day == r_alm_day[i])) begin
                w_match    = 1'b1;
                w_match_id = SW'(i);
            end
        end
    end

    // Arm bit of the slot currently ringing or snoozed.
    always_comb begin
        w_ring_armed = 1'b0;
        for (int i = 0; i < NALM; i++) begin
            if (SW'(i) == r_ring_id) w_ring_armed = alarm_en[i];
        end
    end

    // Ringer state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ring_id  <= '0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ring_id  <= w_ring_id_nx;
            r_ring_cnt <= w_ring_cnt_nx;
            r_snz_cnt  <= w_snz_cnt_nx;
        end
    end

    // Ringer next state: stop/disarm beats snooze, snooze beats the tick count.
    always_comb begin
        w_state_nx    = r_state;
        w_ring_id_nx  = r_ring_id;
        w_ring_cnt_nx = r_ring_cnt;
        w_snz_cnt_nx  = r_snz_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_match) begin
                    w_state_nx    = ST_RING;
                    w_ring_id_nx  = w_match_id;
                    w_ring_cnt_nx = '0;
                end
            end
            ST_RING: begin
                if (stop || !w_ring_armed) begin
                    w_state_nx = ST_IDLE;
                end else if (snooze) begin
                    w_state_nx   = ST_SNOOZE;
                    w_snz_cnt_nx = SNZ_LOAD;
                end else if (tick) begin
                    if (r_ring_cnt == RING_MAX) w_state_nx = ST_IDLE;
                    else                        w_ring_cnt_nx = r_ring_cnt + RCW'(1);
                end
            end
            ST_SNOOZE: begin
                if (stop || !w_ring_armed) begin
                    w_state_nx = ST_IDLE;
                end else if (tick) begin
                    if (r_snz_cnt == '0) begin
                        w_state_nx    = ST_RING;
                        w_ring_cnt_nx = '0;
                    end else begin
                        w_snz_cnt_nx = r_snz_cnt - SCW'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Display mux: alarm-set view shows the selected slot, seconds always show time.
    always_comb begin
        disp_sec = r_sec;
        disp_min = r_min;
        disp_hrs = r_hrs;
        disp_day = r_day;
        if (w_alm_view) begin
            disp_min = '0;
            disp_hrs = '0;
            disp_day = '0;
            for (int i = 0; i < NALM; i++) begin
                if (SW'(i) == sel) begin
                    disp_min = r_alm_min[i];
                    disp_hrs = r_alm_hrs[i];
                    disp_day = r_alm_day[i];
                end
            end
        end
    end

    assign buzz    = (r_state == ST_RING);
    assign ring_id = r_ring_id;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: scenario bench for multi_alarm_clock (default
// parameters). Expectations are queued as stimulus is driven and drained
// against the DUT outputs on the falling clock edge.
module tb_multi_alarm_clock;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, timeset, alarmset, minadv, hrsadv, dayadv;
    logic [1:0] sel;
    logic [3:0] alarm_en;
    logic       snooze, stop;
    logic [6:0] disp_sec, disp_min, disp_hrs, disp_day;
    logic       buzz;
    logic [1:0] ring_id;

    int n_total = 0;
    int n_bad   = 0;

    typedef enum {F_SEC, F_MIN, F_HRS, F_DAY, F_BUZZ, F_RID} field_e;
    typedef struct {
        string  tag;
        field_e fld;
        int     exp;
    } exp_t;

    exp_t sb_q[$];

    multi_alarm_clock dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .timeset  (timeset),
        .alarmset (alarmset),
        .minadv   (minadv),
        .hrsadv   (hrsadv),
        .dayadv   (dayadv),
        .sel      (sel),
        .alarm_en (alarm_en),
        .snooze   (snooze),
        .stop     (stop),
        .disp_sec (disp_sec),
        .disp_min (disp_min),
        .disp_hrs (disp_hrs),
        .disp_day (disp_day),
        .buzz     (buzz),
        .ring_id  (ring_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input field_e f);
        case (f)
            F_SEC:   return 32'(disp_sec);
            F_MIN:   return 32'(disp_min);
            F_HRS:   return 32'(disp_hrs);
            F_DAY:   return 32'(disp_day);
            F_BUZZ:  return 32'(buzz);
            default: return 32'(ring_id);
        endcase
    endfunction

    task automatic expect_val(input string tag, input field_e f, input int v);
        exp_t e;
        e.tag = tag;
        e.fld = f;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_time(input string tag, input int s, input int m, input int h, input int d);
        expect_val({tag, ".sec"}, F_SEC, s);
        expect_val({tag, ".min"}, F_MIN, m);
        expect_val({tag, ".hrs"}, F_HRS, h);
        expect_val({tag, ".day"}, F_DAY, d);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.fld), 32'(e.exp));
        end
    endtask

    // Each tick is a one-cycle pulse followed by a quiet cycle; returns on the
    // falling edge right after the tick has been sampled.
    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        tick     = 1'b0;
        timeset  = 1'b0;
        alarmset = 1'b0;
        minadv   = 1'b0;
        hrsadv   = 1'b0;
        dayadv   = 1'b0;
        sel      = 2'd0;
        alarm_en = 4'b0000;
        snooze   = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Put slot s at 00:01 day 0 with one alarm-set tick (time also advances 1 s).
    task automatic set_slot_0001(input logic [1:0] s);
        alarmset = 1'b1;
        sel      = s;
        minadv   = 1'b1;
        do_ticks(1);
        alarmset = 1'b0;
        minadv   = 1'b0;
        sel      = 2'd0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values.
        expect_time("reset", 0, 0, 0, 0);
        expect_val("reset.buzz", F_BUZZ, 0);
        expect_val("reset.rid", F_RID, 0);
        drain();
        rst = 1'b0;

        // Hour and day rollover.
        expect_time("hour", 0, 0, 1, 0);
        do_ticks(3600);
        drain();
        timeset = 1'b1;
        hrsadv  = 1'b1;
        expect_time("set23", 0, 0, 23, 0);
        do_ticks(22);
        drain();
        timeset = 1'b0;
        hrsadv  = 1'b0;
        expect_time("dayroll", 0, 0, 0, 1);
        do_ticks(3600);
        drain();

        // Single alarm on slot 2: latency, ring_id, auto-timeout.
        do_reset();
        alarmset = 1'b1;
        sel      = 2'd2;
        minadv   = 1'b1;
        expect_val("a2set.view_min", F_MIN, 1);
        expect_val("a2set.sec", F_SEC, 1);
        do_ticks(1);
        drain();
        alarmset = 1'b0;
        minadv   = 1'b0;
        sel      = 2'd0;
        alarm_en = 4'b0100;
        expect_val("a2.pre_buzz", F_BUZZ, 0);
        do_ticks(58);
        drain();
        expect_val("a2.wrap_cycle_buzz", F_BUZZ, 0);
        expect_time("a2.wrap_time", 0, 1, 0, 0);
        do_ticks(1);
        drain();
        expect_val("a2.rise_buzz", F_BUZZ, 1);
        expect_val("a2.rid", F_RID, 2);
        @(negedge clk);
        drain();
        expect_val("a2.ring59", F_BUZZ, 1);
        do_ticks(59);
        drain();
        expect_val("a2.timeout", F_BUZZ, 0);
        do_ticks(1);
        drain();

        // Slots 1 and 3 equal: lowest wins, only one ring.
        do_reset();
        set_slot_0001(2'd1);
        set_slot_0001(2'd3);
        alarm_en = 4'b1010;
        do_ticks(58);
        @(negedge clk);
        expect_val("dual.buzz", F_BUZZ, 1);
        expect_val("dual.rid", F_RID, 1);
        drain();
        expect_val("dual.timeout", F_BUZZ, 0);
        do_ticks(60);
        drain();
        expect_val("dual.no_second", F_BUZZ, 0);
        expect_val("dual.rid_hold", F_RID, 1);
        do_ticks(10);
        drain();

        // Snooze re-ring after exactly 540 ticks, then stop.
        do_reset();
        set_slot_0001(2'd0);
        alarm_en = 4'b0001;
        do_ticks(59);
        @(negedge clk);
        expect_val("snz.ring", F_BUZZ, 1);
        drain();
        snooze = 1'b1;
        expect_val("snz.drop", F_BUZZ, 0);
        @(negedge clk);
        snooze = 1'b0;
        drain();
        expect_val("snz.539", F_BUZZ, 0);
        do_ticks(539);
        drain();
        expect_val("snz.540", F_BUZZ, 1);
        expect_val("snz.rid", F_RID, 0);
        do_ticks(1);
        drain();
        stop = 1'b1;
        expect_val("stop.drop", F_BUZZ, 0);
        @(negedge clk);
        stop = 1'b0;
        drain();
        expect_val("stop.stays_low", F_BUZZ, 0);
        do_ticks(5);
        drain();

        // Disarming the ringing slot ends the ring.
        do_reset();
        set_slot_0001(2'd0);
        alarm_en = 4'b0001;
        do_ticks(59);
        @(negedge clk);
        expect_val("disarm.ring", F_BUZZ, 1);
        drain();
        alarm_en = 4'b0000;
        expect_val("disarm.drop", F_BUZZ, 0);
        @(negedge clk);
        drain();

        // Time set: no carry, seconds hold, no trigger.
        do_reset();
        alarmset = 1'b1;
        minadv   = 1'b1;
        do_ticks(5);
        alarmset = 1'b0;
        minadv   = 1'b0;
        alarm_en = 4'b0001;
        do_ticks(54);
        timeset = 1'b1;
        minadv  = 1'b1;
        expect_time("tset", 59, 5, 0, 0);
        do_ticks(5);
        drain();
        timeset = 1'b0;
        minadv  = 1'b0;
        expect_time("tset.run", 0, 6, 0, 0);
        do_ticks(1);
        drain();
        expect_val("tset.no_ring", F_BUZZ, 0);
        @(negedge clk);
        drain();

        // timeset wins over alarmset: time hours advance, slot 0 holds.
        timeset  = 1'b1;
        alarmset = 1'b1;
        hrsadv   = 1'b1;
        do_ticks(3);
        timeset  = 1'b0;
        alarmset = 1'b0;
        hrsadv   = 1'b0;
        #1;
        expect_time("both", 0, 6, 3, 0);
        drain();
        alarmset = 1'b1;
        #1;
        expect_val("both.slot_hrs", F_HRS, 0);
        expect_val("both.slot_min", F_MIN, 5);
        expect_val("both.view_sec", F_SEC, 0);
        drain();
        alarmset = 1'b0;

        // Reset during RING.
        do_reset();
        set_slot_0001(2'd3);
        alarm_en = 4'b1000;
        do_ticks(59);
        @(negedge clk);
        expect_val("rstring.ring", F_BUZZ, 1);
        expect_val("rstring.rid", F_RID, 3);
        drain();
        rst = 1'b1;
        expect_val("rstring.buzz", F_BUZZ, 0);
        expect_val("rstring.rid0", F_RID, 0);
        expect_time("rstring", 0, 0, 0, 0);
        @(negedge clk);
        drain();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
